// File: rtl/mul64_seq_ctrl.sv
// Sequential unsigned 64x64 -> 128-bit shift-add multiplier controller.
// One 64-bit carry-lookahead adder (8 x cla8) is reused across 64 iterations.

module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carry lookahead: each carry is a flattened sum of generate/propagate terms
  always_comb begin
    c = '0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      logic term;
      logic acc;
      acc = g[i];
      for (int j = i - 1; j >= -1; j--) begin
        term = (j >= 0) ? g[j] : ci;
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign s  = p ^ c[7:0];
  assign co = c[8];

endmodule

module cla64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        ci,
  output logic [63:0] s,
  output logic        co
);

  localparam int unsigned N_BLK = 8;

  logic [N_BLK:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < N_BLK; gi++) begin : g_blk
    cla8 u_cla8 (
      .a  (a[gi*8 +: 8]),
      .b  (b[gi*8 +: 8]),
      .ci (c[gi]),
      .s  (s[gi*8 +: 8]),
      .co (c[gi+1])
    );
  end

  assign co = c[N_BLK];

endmodule

module mul64_seq_ctrl #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   result,
  output logic                 op_busy,
  output logic                 op_done
);

  localparam int unsigned CNT_W    = 7;
  localparam int unsigned LAST_IT  = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] p_r;

  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_s;
  logic               add_co;

  assign hi    = p_r[2*WIDTH-1:WIDTH];
  assign lo    = p_r[WIDTH-1:0];
  assign add_b = lo[0] ? mcand_r : '0;

  cla64 u_add (
    .a  (hi),
    .b  (add_b),
    .ci (1'b0),
    .s  (add_s),
    .co (add_co)
  );

  // Control and datapath; busy/done are registered alongside the state they decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand_r <= '0;
      p_r     <= '0;
      op_busy <= 1'b0;
      op_done <= 1'b0;
    end else if (op_clear) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand_r <= '0;
      p_r     <= '0;
      op_busy <= 1'b0;
      op_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (op_start) begin
            mcand_r <= multiplicand;
            p_r     <= {{WIDTH{1'b0}}, multiplier};
            cnt     <= '0;
            state   <= EXEC;
            op_busy <= 1'b1;
            op_done <= 1'b0;
          end
        end
        EXEC: begin
          // Add-then-shift; the adder carry lands in the top product bit
          p_r <= {add_co, add_s, lo[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(LAST_IT)) begin
            state   <= DONE;
            op_busy <= 1'b0;
            op_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          op_busy <= 1'b0;
          op_done <= 1'b0;
        end
      endcase
    end
  end

  assign result = p_r;

endmodule

// File: tb/tb_mul64_seq_ctrl.sv
// Directed self-checking bench for mul64_seq_ctrl.

module tb_mul64_seq_ctrl;

  logic         clk;
  logic         reset_n;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  multiplicand;
  logic [63:0]  multiplier;
  logic [127:0] result;
  logic         op_busy;
  logic         op_done;

  int checks;
  int errors;
  int cyc;
  int bad;

  mul64_seq_ctrl #(.WIDTH(64)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .op_busy      (op_busy),
    .op_done      (op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    multiplicand = a;
    multiplier   = b;
    op_start     = 1'b1;
    tick();
    op_start     = 1'b0;
  endtask

  // Count edges until op_done (bounded); flag any cycle that is neither busy-only nor done-only
  task automatic wait_done(output int n, output int nbad);
    n    = 0;
    nbad = 0;
    for (int i = 0; i < 200; i++) begin
      if (!op_busy || op_done) nbad++;
      tick();
      n++;
      if (op_done) break;
    end
    if (!(op_done && !op_busy)) nbad++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    op_start = 1'b0;
    op_clear = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    #1;
    chk("reset_result", result, 128'h0);
    chk("reset_busy", 128'(op_busy), 128'h0);
    chk("reset_done", 128'(op_done), 128'h0);
    #12;
    reset_n = 1'b1;
    tick();

    // 3 x 5
    start_op(64'd3, 64'd5);
    chk("start_busy", 128'(op_busy), 128'h1);
    wait_done(cyc, bad);
    chk("lat_3x5", 128'(cyc), 128'd64);
    chk("flags_3x5", 128'(bad), 128'd0);
    chk("res_3x5", result, 128'h0F);
    tick();
    chk("hold_done", 128'(op_done), 128'h1);
    chk("hold_res", result, 128'h0F);

    // All-ones squared, relies on carry-out capture
    op_clear = 1'b1; tick(); op_clear = 1'b0;
    chk("clear_done", 128'(op_done), 128'h0);
    chk("clear_res", result, 128'h0);
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(cyc, bad);
    chk("lat_ones", 128'(cyc), 128'd64);
    chk("res_ones", result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Top multiplicand bit set: 0x8000..0001 x 3
    start_op(64'h8000_0000_0000_0001, 64'd3);
    wait_done(cyc, bad);
    chk("res_top", result, 128'h1_8000_0000_0000_0003);

    // Zero multiplier
    start_op(64'h1234_5678_9ABC_DEF0, 64'd0);
    wait_done(cyc, bad);
    chk("lat_zero", 128'(cyc), 128'd64);
    chk("done_zero", 128'(op_done), 128'h1);
    chk("res_zero", result, 128'h0);

    // 7 x 9 with a start during EXEC that must be ignored
    start_op(64'd7, 64'd9);
    for (int i = 0; i < 20; i++) tick();
    start_op(64'd1000, 64'd1000);
    chk("ign_busy", 128'(op_busy), 128'h1);
    wait_done(cyc, bad);
    chk("lat_ign", 128'(cyc), 128'd43);
    chk("flags_ign", 128'(bad), 128'd0);
    chk("res_ign", result, 128'd63);

    // Back-to-back start from DONE: 2^32 x 2^32
    start_op(64'h1_0000_0000, 64'h1_0000_0000);
    chk("b2b_done", 128'(op_done), 128'h0);
    chk("b2b_busy", 128'(op_busy), 128'h1);
    wait_done(cyc, bad);
    chk("lat_b2b", 128'(cyc), 128'd64);
    chk("res_b2b", result, 128'h1_0000_0000_0000_0000);

    // Clear mid-EXEC aborts with no done
    start_op(64'd7, 64'd9);
    for (int i = 0; i < 20; i++) tick();
    op_clear = 1'b1; tick(); op_clear = 1'b0;
    chk("abort_busy", 128'(op_busy), 128'h0);
    chk("abort_res", result, 128'h0);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      if (op_done || op_busy) bad++;
      tick();
    end
    chk("abort_nodone", 128'(bad), 128'd0);

    // Clear beats start in the same cycle
    multiplicand = 64'd2; multiplier = 64'd2;
    op_start = 1'b1; op_clear = 1'b1; tick();
    op_start = 1'b0; op_clear = 1'b0;
    chk("prio_busy", 128'(op_busy), 128'h0);
    tick();
    chk("prio_idle", 128'(op_busy), 128'h0);

    // Asynchronous reset mid-EXEC
    start_op(64'd3, 64'd5);
    for (int i = 0; i < 10; i++) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_res", result, 128'h0);
    chk("arst_busy", 128'(op_busy), 128'h0);
    chk("arst_done", 128'(op_done), 128'h0);
    tick();
    reset_n = 1'b1;
    tick();
    start_op(64'd3, 64'd5);
    wait_done(cyc, bad);
    chk("lat_post", 128'(cyc), 128'd64);
    chk("res_post", result, 128'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul64_seq_ctrl.md
Name: mul64_seq_ctrl

Overview:
- Sequential unsigned 64x64 -> 128-bit shift-add multiplier controller for the ALU/multiplier subsystem.
- Owns a single 64-bit carry-lookahead adder instance (8 x cla8 chained) and sequences it over 64 iterations.
- Start/done handshake to the ALU top, plus a synchronous clear/abort input.

Parameters:
- WIDTH, 64, operand width. Only 64 is supported because the adder is fixed 64-bit; other values are illegal.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- op_start  input  1  start request, sampled at rising edge
- op_clear  input  1  synchronous abort/clear
- multiplicand  input  64  operand A, latched on accepted start
- multiplier  input  64  operand B, latched on accepted start
- result  output  128  product register; valid when op_done=1
- op_busy  output  1  high while state=EXEC
- op_done  output  1  high while state=DONE

Behaviour:
- Registers:
  - state {IDLE, EXEC, DONE}
  - 7-bit iteration count cnt
  - 64-bit mcand_r
  - 128-bit product register P = {hi[63:0], lo[63:0]}
  - result = P at all times
- Reset (reset_n=0, asynchronous): state=IDLE, cnt=0, mcand_r=0, P=0, so result=0, op_busy=0, op_done=0.
- Adder hookup: a=hi, b=(lo[0] ? mcand_r : 0), ci=0 -> sum s[63:0], carry co.
- IDLE:
  - op_start=1 & op_clear=0: mcand_r<=multiplicand, hi<=0, lo<=multiplier, cnt<=0, state<=EXEC.
  - Otherwise hold.
- EXEC, each cycle: P <= {co, s, lo[63:1]} (add-then-shift right by 1); cnt<=cnt+1.
  - When cnt==63 on that edge, state<=DONE.
  - Exactly 64 EXEC cycles.
- DONE:
  - op_done=1; P holds the final product; stays until op_clear or op_start.
  - op_start=1 in DONE: loads new operands exactly as in IDLE and goes to EXEC. This is the back-to-back path with no IDLE cycle.
- Latency: start accepted at edge k -> op_busy=1 after edges k..k+63 -> op_done=1 after edge k+64, product valid from then on.
- op_start while in EXEC: ignored; operands not re-latched.
- op_clear=1 (any state): state<=IDLE, P<=0, cnt<=0, mcand_r<=0 at the next edge.
  - Has priority over op_start in the same cycle.
- Asynchronous reset mid-EXEC: immediately returns to the reset values above; no done pulse.
- The carry out of the adder must be captured as P[127] on every iteration. Dropping it is a functional bug for operands >= 2^63.
- op_busy and op_done are mutually exclusive and decode directly from state. No combinational path from inputs to outputs.
- result during EXEC is an intermediate value and must not be consumed.

Test Plan:
- Reset, then multiplicand=3, multiplier=5, pulse op_start -> op_busy high 64 cycles; op_done rises 64 edges after start; result=128'h0F.
- multiplicand=multiplier=64'hFFFF_FFFF_FFFF_FFFF -> result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 (exercises the carry-out capture).
- multiplicand=64'h1234_5678_9ABC_DEF0, multiplier=0 -> result=0 after 64 cycles; op_done=1.
- Start 7x9; at EXEC cycle 20 assert op_start with new operands -> ignored; result=63. Repeat with op_clear at cycle 20 -> next cycle state IDLE, result=0, op_busy=0, op_done never asserts.
- In DONE (result 63), assert op_start with 2^32 x 2^32 -> op_done drops next edge, EXEC 64 cycles, result=128'h1_0000_0000_0000_0000 (2^64).
- Drop reset_n asynchronously mid-EXEC -> result=0, op_busy=0, op_done=0 without waiting for a clock edge. After release, a new 3x5 gives 15.
